avl_arb2: RTL and testbench
===========================

Name: avl_arb2

Overview:
- Two-master to one-slave Avalon-MM arbiter for the J2 SoC memory-mapped slaves.
- Sits between two AHB-to-Avalon bridge outputs (CPU data side and a second AHB master, e.g. DMA/debug) and a single Avalon slave, such as on-chip SRAM or a peripheral register block.
- Fair round-robin, one transfer per grant; owner signals pass through combinationally to the slave.
- Uses single-transfer Avalon with waitrequest only: no bursts, no pipelined reads.

Parameters:
- ADDR_W, 16, word-address width (byte-address bits [ADDR_W+1:2]).
- DATA_W, 32, data width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- m0_chipselect  in  1  master 0 request.
- m0_read_n  in  1  master 0 read strobe, active low.
- m0_write_n  in  1  master 0 write strobe, active low.
- m0_address  in  ADDR_W  master 0 word address.
- m0_writedata  in  DATA_W  master 0 write data.
- m0_readdata  out  DATA_W  read data to master 0.
- m0_waitrequest  out  1  stall to master 0.
- m1_*  same set and widths as m0_*, for master 1.
- s_chipselect  out  1  slave select.
- s_read_n  out  1  slave read strobe, active low.
- s_write_n  out  1  slave write strobe, active low.
- s_address  out  ADDR_W  slave word address.
- s_writedata  out  DATA_W  slave write data.
- s_readdata  in  DATA_W  slave read data.
- s_waitrequest  in  1  slave stall; meaningful only while s_chipselect=1.
- owner  out  2  debug: 00 idle, 01 master 0, 10 master 1.

Behaviour:
- Registers: state {IDLE, OWN0, OWN1} and a last-served bit `last`.
  - Reset: state=IDLE, last=1, so master 0 wins the first tie.
- Master obligations (Avalon rule): while its waitrequest=1, a master holds chipselect, strobes, address and writedata stable.
- Transfer completion: in OWNx, m_x_chipselect=1 and s_waitrequest=0 in the same cycle. On that edge, last<=x.
- Slave-side outputs (combinational from state):
  - IDLE: s_chipselect=0, s_read_n=1, s_write_n=1, s_address=0, s_writedata=0.
  - OWNx: all s_* equal master x's inputs.
- Master-side outputs:
  - m_x_waitrequest = s_waitrequest when state=OWNx; otherwise 1, including IDLE.
  - m0_readdata and m1_readdata both equal s_readdata; only the owner samples it.
- State transitions, evaluated each clock edge:
  - IDLE: only m0 requests -> OWN0; only m1 -> OWN1.
  - IDLE, both request: grant the master != last.
  - IDLE, no request: stay IDLE.
  - OWNx, completion: if m_y_chipselect=1 -> OWNy; else stay OWNx. This allows back-to-back transfers from x with no bubble.
  - OWNx, m_x_chipselect=0: if m_y_chipselect=1 -> OWNy; else -> IDLE.
  - OWNx, m_x_chipselect=1 and s_waitrequest=1: stay OWNx. A grant is never revoked mid-transfer.
- Latency:
  - From IDLE: request at cycle t -> slave sees chipselect at t+1. Minimum 2-cycle transfer for a zero-wait slave.
  - Owner back-to-back: 1 transfer per cycle.
- Fairness: a waiting master is granted no later than immediately after the current owner's in-flight transfer completes, so bounded wait is one transfer.
- Simultaneous events:
  - Owner completes while the other master requests: switch, even if the owner re-requests.
  - Both request in IDLE: decided by `last`.
- Reset mid-transfer:
  - State returns to IDLE on the reset edge, so s_chipselect=0 from the next cycle.
  - The aborted transfer is not replayed; masters are reset by the same rst.
- Timing note: s_* outputs are combinational from state and master inputs; there is no combinational path from s_waitrequest to any s_* output.
- owner output: 00 in IDLE, 01 in OWN0, 10 in OWN1.

Test Plan:
- Reset, then m0 writes 0xDEADBEEF to address 0x0010 against a zero-wait slave:
  - cycle 0: m0_waitrequest=1, s_chipselect=0.
  - cycle 1: s_chipselect=1, s_write_n=0, s_address=0x0010, m0_waitrequest=0; then IDLE once m0 drops chipselect.
- m0 and m1 assert read in the same cycle after reset:
  - m0 is served first, then m1.
  - owner sequence 00, 01, 10, 00.
  - m1 sees s_readdata=0x12345678 when the slave returns it.
- m0 issues 4 back-to-back reads, slave zero-wait, m1 idle:
  - 4 transfers in 4 consecutive cycles after the first grant.
  - owner stays 01 throughout.
- m0 continuously requesting and m1 continuously requesting:
  - grants strictly alternate 01, 10, 01, 10.
  - each master completes exactly one transfer per grant.
- Slave holds waitrequest=1 for 3 cycles during an m1 write while m0 requests:
  - owner stays 10 and all s_* stay stable for 4 cycles.
  - m0_waitrequest=1 throughout; the grant moves to m0 on the completion edge.
- rst asserted while in OWN1 with s_waitrequest=1:
  - next cycle state=IDLE, owner=00, s_chipselect=0, s_read_n=1, s_write_n=1.
  - the first subsequent tie goes to m0.

Source files
------------

// File: rtl/avl_arb2.sv
// Two-master to one-slave Avalon-MM arbiter: fair round-robin, one transfer per grant.
// The owning master's signals pass straight through to the slave; the other master is stalled.
module avl_arb2 #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_chipselect,
  input  logic              m0_read_n,
  input  logic              m0_write_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_waitrequest,

  input  logic              m1_chipselect,
  input  logic              m1_read_n,
  input  logic              m1_write_n,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_waitrequest,

  output logic              s_chipselect,
  output logic              s_read_n,
  output logic              s_write_n,
  output logic [ADDR_W-1:0] s_address,
  output logic [DATA_W-1:0] s_writedata,
  input  logic [DATA_W-1:0] s_readdata,
  input  logic              s_waitrequest,

  output logic [1:0]        owner
);

  // Encoding doubles as the debug owner code.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t state, state_nxt;
  logic   last, last_nxt;   // master served most recently; the other one wins a tie

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    state_nxt = state;
    last_nxt  = last;
    unique case (state)
      IDLE: begin
        if (m0_chipselect && m1_chipselect) state_nxt = last ? OWN0 : OWN1;
        else if (m0_chipselect)             state_nxt = OWN0;
        else if (m1_chipselect)             state_nxt = OWN1;
      end
      OWN0: begin
        if (!m0_chipselect) begin
          state_nxt = m1_chipselect ? OWN1 : IDLE;
        end else if (!s_waitrequest) begin
          last_nxt = 1'b0;
          if (m1_chipselect) state_nxt = OWN1;
        end
      end
      OWN1: begin
        if (!m1_chipselect) begin
          state_nxt = m0_chipselect ? OWN0 : IDLE;
        end else if (!s_waitrequest) begin
          last_nxt = 1'b1;
          if (m0_chipselect) state_nxt = OWN0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Slave mux depends only on state and master inputs, never on s_waitrequest.
  always_comb begin
    s_chipselect = 1'b0;
    s_read_n     = 1'b1;
    s_write_n    = 1'b1;
    s_address    = '0;
    s_writedata  = '0;
    unique case (state)
      OWN0: begin
        s_chipselect = m0_chipselect;
        s_read_n     = m0_read_n;
        s_write_n    = m0_write_n;
        s_address    = m0_address;
        s_writedata  = m0_writedata;
      end
      OWN1: begin
        s_chipselect = m1_chipselect;
        s_read_n     = m1_read_n;
        s_write_n    = m1_write_n;
        s_address    = m1_address;
        s_writedata  = m1_writedata;
      end
      default: ;
    endcase
  end

  assign m0_waitrequest = (state == OWN0) ? s_waitrequest : 1'b1;
  assign m1_waitrequest = (state == OWN1) ? s_waitrequest : 1'b1;
  assign m0_readdata    = s_readdata;
  assign m1_readdata    = s_readdata;
  assign owner          = state;

endmodule

// File: tb/tb_avl_arb2.sv
// Bench for avl_arb2: directed vector table, a reset-mid-transfer sequence,
// then random masters/slave checked against a behavioural arbitration model.
module tb_avl_arb2;

  localparam int AW = 16;
  localparam int DW = 32;

  typedef struct packed {
    logic          cs;
    logic          rd_n;
    logic          wr_n;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } bus_t;

  typedef struct {
    logic          rst;
    bus_t          m0;
    bus_t          m1;
    logic [DW-1:0] srd;
    logic          swait;
    logic [1:0]    own;
    bus_t          s;
    logic          wt0;
    logic          wt1;
  } vec_t;

  logic          clk;
  logic          rst;
  logic          m0_chipselect, m0_read_n, m0_write_n;
  logic [AW-1:0] m0_address;
  logic [DW-1:0] m0_writedata, m0_readdata;
  logic          m0_waitrequest;
  logic          m1_chipselect, m1_read_n, m1_write_n;
  logic [AW-1:0] m1_address;
  logic [DW-1:0] m1_writedata, m1_readdata;
  logic          m1_waitrequest;
  logic          s_chipselect, s_read_n, s_write_n;
  logic [AW-1:0] s_address;
  logic [DW-1:0] s_writedata, s_readdata;
  logic          s_waitrequest;
  logic [1:0]    owner;

  avl_arb2 #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .m0_chipselect  (m0_chipselect),
    .m0_read_n      (m0_read_n),
    .m0_write_n     (m0_write_n),
    .m0_address     (m0_address),
    .m0_writedata   (m0_writedata),
    .m0_readdata    (m0_readdata),
    .m0_waitrequest (m0_waitrequest),
    .m1_chipselect  (m1_chipselect),
    .m1_read_n      (m1_read_n),
    .m1_write_n     (m1_write_n),
    .m1_address     (m1_address),
    .m1_writedata   (m1_writedata),
    .m1_readdata    (m1_readdata),
    .m1_waitrequest (m1_waitrequest),
    .s_chipselect   (s_chipselect),
    .s_read_n       (s_read_n),
    .s_write_n      (s_write_n),
    .s_address      (s_address),
    .s_writedata    (s_writedata),
    .s_readdata     (s_readdata),
    .s_waitrequest  (s_waitrequest),
    .owner          (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bus_t idle_b();
    bus_t b;
    b.cs = 1'b0; b.rd_n = 1'b1; b.wr_n = 1'b1; b.addr = '0; b.wdata = '0;
    return b;
  endfunction

  function automatic bus_t rd_b(input logic [AW-1:0] a);
    bus_t b;
    b.cs = 1'b1; b.rd_n = 1'b0; b.wr_n = 1'b1; b.addr = a; b.wdata = '0;
    return b;
  endfunction

  function automatic bus_t wr_b(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus_t b;
    b.cs = 1'b1; b.rd_n = 1'b1; b.wr_n = 1'b0; b.addr = a; b.wdata = d;
    return b;
  endfunction

  function automatic bus_t rand_b();
    bus_t b;
    if ($urandom_range(0, 3) == 0) return idle_b();
    b.cs    = 1'b1;
    b.rd_n  = 1'($urandom_range(0, 1));
    b.wr_n  = ~b.rd_n;
    b.addr  = AW'($urandom());
    b.wdata = $urandom();
    return b;
  endfunction

  function automatic vec_t vr(input logic r, input bus_t a, input bus_t b,
                              input logic [DW-1:0] srd, input logic sw,
                              input logic [1:0] own, input bus_t s,
                              input logic w0, input logic w1);
    vec_t v;
    v.rst = r; v.m0 = a; v.m1 = b; v.srd = srd; v.swait = sw;
    v.own = own; v.s = s; v.wt0 = w0; v.wt1 = w1;
    return v;
  endfunction

  // Inputs change 1 unit after the rising edge; outputs are sampled 4 units later.
  task automatic drive(input logic r, input bus_t a, input bus_t b,
                       input logic [DW-1:0] srd, input logic sw);
    rst = r;
    m0_chipselect = a.cs; m0_read_n = a.rd_n; m0_write_n = a.wr_n;
    m0_address = a.addr;  m0_writedata = a.wdata;
    m1_chipselect = b.cs; m1_read_n = b.rd_n; m1_write_n = b.wr_n;
    m1_address = b.addr;  m1_writedata = b.wdata;
    s_readdata = srd;     s_waitrequest = sw;
    #4;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_outputs(input string tag, input logic [1:0] own, input bus_t s,
                                input logic w0, input logic w1, input logic [DW-1:0] srd);
    check({tag, " owner"},          64'(owner),          64'(own));
    check({tag, " s_chipselect"},   64'(s_chipselect),   64'(s.cs));
    check({tag, " s_read_n"},       64'(s_read_n),       64'(s.rd_n));
    check({tag, " s_write_n"},      64'(s_write_n),      64'(s.wr_n));
    check({tag, " s_address"},      64'(s_address),      64'(s.addr));
    check({tag, " s_writedata"},    64'(s_writedata),    64'(s.wdata));
    check({tag, " m0_waitrequest"}, 64'(m0_waitrequest), 64'(w0));
    check({tag, " m1_waitrequest"}, 64'(m1_waitrequest), 64'(w1));
    check({tag, " m0_readdata"},    64'(m0_readdata),    64'(srd));
    check({tag, " m1_readdata"},    64'(m1_readdata),    64'(srd));
  endtask

  vec_t vecs[$];

  // Behavioural model: who owns the slave (0 none, 1 master 0, 2 master 1) and who was served last.
  int   own_m;
  int   last_m;
  bus_t mst[2];
  logic hold[2];
  logic ew[2];

  initial begin
    bus_t          i_b;
    bus_t          exp_s;
    logic          r, sw, done;
    logic [DW-1:0] srd;
    int            x, y;

    i_b = idle_b();

    // Master 0 single write, zero-wait slave
    vecs.push_back(vr(0, wr_b(16'h0010, 32'hDEADBEEF), i_b, 0, 0, 2'b00, i_b, 1, 1));
    vecs.push_back(vr(0, wr_b(16'h0010, 32'hDEADBEEF), i_b, 0, 0, 2'b01, wr_b(16'h0010, 32'hDEADBEEF), 0, 1));
    vecs.push_back(vr(0, i_b, i_b, 0, 0, 2'b01, i_b, 0, 1));
    vecs.push_back(vr(0, i_b, i_b, 0, 0, 2'b00, i_b, 1, 1));
    // Reset, then simultaneous reads: master 0 first, then master 1
    vecs.push_back(vr(1, i_b, i_b, 0, 0, 2'b00, i_b, 1, 1));
    vecs.push_back(vr(0, rd_b(16'h0020), rd_b(16'h0030), 0, 0, 2'b00, i_b, 1, 1));
    vecs.push_back(vr(0, rd_b(16'h0020), rd_b(16'h0030), 32'hAAAA0000, 0, 2'b01, rd_b(16'h0020), 0, 1));
    vecs.push_back(vr(0, i_b, rd_b(16'h0030), 32'h12345678, 0, 2'b10, rd_b(16'h0030), 1, 0));
    vecs.push_back(vr(0, i_b, i_b, 0, 0, 2'b10, i_b, 1, 0));
    vecs.push_back(vr(0, i_b, i_b, 0, 0, 2'b00, i_b, 1, 1));
    // Master 0 back-to-back reads
    vecs.push_back(vr(0, rd_b(16'h0040), i_b, 0, 0, 2'b00, i_b, 1, 1));
    vecs.push_back(vr(0, rd_b(16'h0040), i_b, 1, 0, 2'b01, rd_b(16'h0040), 0, 1));
    vecs.push_back(vr(0, rd_b(16'h0041), i_b, 2, 0, 2'b01, rd_b(16'h0041), 0, 1));
    vecs.push_back(vr(0, rd_b(16'h0042), i_b, 3, 0, 2'b01, rd_b(16'h0042), 0, 1));
    vecs.push_back(vr(0, rd_b(16'h0043), i_b, 4, 0, 2'b01, rd_b(16'h0043), 0, 1));
    vecs.push_back(vr(0, i_b, i_b, 0, 0, 2'b01, i_b, 0, 1));
    vecs.push_back(vr(0, i_b, i_b, 0, 0, 2'b00, i_b, 1, 1));
    // Both masters continuously requesting: strict alternation
    vecs.push_back(vr(1, i_b, i_b, 0, 0, 2'b00, i_b, 1, 1));
    vecs.push_back(vr(0, rd_b(16'h0050), wr_b(16'h0060, 32'h11111111), 0, 0, 2'b00, i_b, 1, 1));
    vecs.push_back(vr(0, rd_b(16'h0050), wr_b(16'h0060, 32'h11111111), 0, 0, 2'b01, rd_b(16'h0050), 0, 1));
    vecs.push_back(vr(0, rd_b(16'h0051), wr_b(16'h0060, 32'h11111111), 0, 0, 2'b10, wr_b(16'h0060, 32'h11111111), 1, 0));
    vecs.push_back(vr(0, rd_b(16'h0051), wr_b(16'h0061, 32'h22222222), 0, 0, 2'b01, rd_b(16'h0051), 0, 1));
    vecs.push_back(vr(0, rd_b(16'h0052), wr_b(16'h0061, 32'h22222222), 0, 0, 2'b10, wr_b(16'h0061, 32'h22222222), 1, 0));
    vecs.push_back(vr(0, i_b, i_b, 0, 0, 2'b01, i_b, 0, 1));
    vecs.push_back(vr(0, i_b, i_b, 0, 0, 2'b00, i_b, 1, 1));
    // Master 1 write stalled 3 cycles while master 0 waits; grant moves on completion
    vecs.push_back(vr(0, i_b, wr_b(16'h0070, 32'hCAFEF00D), 0, 1, 2'b00, i_b, 1, 1));
    vecs.push_back(vr(0, rd_b(16'h0080), wr_b(16'h0070, 32'hCAFEF00D), 0, 1, 2'b10, wr_b(16'h0070, 32'hCAFEF00D), 1, 1));
    vecs.push_back(vr(0, rd_b(16'h0080), wr_b(16'h0070, 32'hCAFEF00D), 0, 1, 2'b10, wr_b(16'h0070, 32'hCAFEF00D), 1, 1));
    vecs.push_back(vr(0, rd_b(16'h0080), wr_b(16'h0070, 32'hCAFEF00D), 0, 1, 2'b10, wr_b(16'h0070, 32'hCAFEF00D), 1, 1));
    vecs.push_back(vr(0, rd_b(16'h0080), wr_b(16'h0070, 32'hCAFEF00D), 0, 0, 2'b10, wr_b(16'h0070, 32'hCAFEF00D), 1, 0));
    vecs.push_back(vr(0, rd_b(16'h0080), i_b, 0, 0, 2'b01, rd_b(16'h0080), 0, 1));
    vecs.push_back(vr(0, i_b, i_b, 0, 0, 2'b01, i_b, 0, 1));
    vecs.push_back(vr(0, i_b, i_b, 0, 0, 2'b00, i_b, 1, 1));

    drive(1, i_b, i_b, 0, 0);
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].m0, vecs[i].m1, vecs[i].srd, vecs[i].swait);
      expect_outputs($sformatf("vec%0d", i), vecs[i].own, vecs[i].s, vecs[i].wt0, vecs[i].wt1, vecs[i].srd);
      tick();
    end

    // Reset while master 1 is stalled; master 0 served last, so the next tie checks last was reset
    drive(0, i_b, wr_b(16'h0090, 32'h55AA55AA), 0, 1);
    check("rstseq idle owner", 64'(owner), 64'(2'b00));
    tick();
    drive(1, i_b, wr_b(16'h0090, 32'h55AA55AA), 0, 1);
    check("rstseq own1 owner", 64'(owner), 64'(2'b10));
    check("rstseq own1 m1_waitrequest", 64'(m1_waitrequest), 64'(1'b1));
    check("rstseq own1 s_chipselect", 64'(s_chipselect), 64'(1'b1));
    tick();
    drive(0, rd_b(16'h00A0), rd_b(16'h00B0), 0, 0);
    check("rstseq after owner", 64'(owner), 64'(2'b00));
    check("rstseq after s_chipselect", 64'(s_chipselect), 64'(1'b0));
    check("rstseq after s_read_n", 64'(s_read_n), 64'(1'b1));
    check("rstseq after s_write_n", 64'(s_write_n), 64'(1'b1));
    tick();
    drive(0, rd_b(16'h00A0), rd_b(16'h00B0), 32'h0BADF00D, 0);
    check("rstseq tie owner", 64'(owner), 64'(2'b01));
    check("rstseq tie s_address", 64'(s_address), 64'(16'h00A0));
    tick();
    drive(0, i_b, rd_b(16'h00B0), 0, 0);
    check("rstseq second owner", 64'(owner), 64'(2'b10));
    tick();

    // Random phase against the model
    drive(1, i_b, i_b, 0, 0);
    tick();
    own_m   = 0;
    last_m  = 1;
    hold[0] = 1'b0;
    hold[1] = 1'b0;
    mst[0]  = i_b;
    mst[1]  = i_b;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int m = 0; m < 2; m++) if (!hold[m]) mst[m] = rand_b();
      r   = ($urandom_range(0, 249) == 0);
      sw  = ($urandom_range(0, 2) == 0);
      srd = $urandom();
      drive(r, mst[0], mst[1], srd, sw);

      exp_s = (own_m == 0) ? i_b : mst[own_m-1];
      for (int m = 0; m < 2; m++) ew[m] = (own_m == m + 1) ? sw : 1'b1;
      expect_outputs($sformatf("rand%0d", cyc), 2'(own_m), exp_s, ew[0], ew[1], srd);

      if (r) begin
        own_m   = 0;
        last_m  = 1;
        hold[0] = 1'b0;
        hold[1] = 1'b0;
      end else begin
        for (int m = 0; m < 2; m++) hold[m] = mst[m].cs && ew[m];
        if (own_m == 0) begin
          if (mst[0].cs && mst[1].cs) own_m = 2 - last_m;
          else if (mst[0].cs)         own_m = 1;
          else if (mst[1].cs)         own_m = 2;
        end else begin
          x    = own_m - 1;
          y    = 1 - x;
          done = mst[x].cs && !sw;
          if (done) last_m = x;
          if (!mst[x].cs || done) own_m = mst[y].cs ? y + 1 : (mst[x].cs ? own_m : 0);
        end
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
